// File: rtl/i2c_pkg.sv
// Shared types for the I2C start/stop/bit generator.
// Command and state encodings plus the per-phase line pattern.
package i2c_pkg;

  localparam int PH_W = 2;

  typedef logic [PH_W-1:0] ph_t;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_STOP  = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_READ  = 2'd3
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Returns {sda_oe, scl_oe}; 1 pulls the line low.
  function automatic logic [1:0] line_oe(
    input cmd_t c,
    input logic wb,
    input ph_t  ph,
    input logic scl_prev
  );
    logic scl_lo;
    scl_lo = (ph == 2'd0) || (ph == 2'd3);
    case (c)
      CMD_START:
        line_oe = {ph[1],
                   (ph == 2'd0) ? scl_prev
                                : (ph == 2'd3)};
      CMD_STOP:  line_oe = {~ph[1], ph == 2'd0};
      CMD_WRITE: line_oe = {~wb, scl_lo};
      default:   line_oe = {1'b0, scl_lo};
    endcase
  endfunction

endpackage

// File: rtl/i2c_qtr_timer.sv
// Quarter-period timer for the I2C generator.
// Counts while enabled and not held; ticks on the wrap cycle.
module i2c_qtr_timer #(
  parameter int unsigned QTR_DIV = 125
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic hold,
  output logic qtr_tick
);

  localparam int CW = (QTR_DIV > 2) ? $clog2(QTR_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(QTR_DIV - 1);

  logic [CW-1:0] cnt;

  assign qtr_tick = enable && !hold && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!enable) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= qtr_tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_start_stop_gen.sv
// I2C master bit-level engine: START, STOP, WRITE and READ
// as four quarter-phases with stretching and arbitration.
module i2c_start_stop_gen
  import i2c_pkg::*;
#(
  parameter int unsigned QTR_DIV = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  input  logic       cmd_wbit,
  output logic       cmd_ready,
  input  logic       sda_in,
  input  logic       scl_in,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic       done,
  output logic       rd_bit,
  output logic       err,
  output logic       arb_lost,
  output logic       bus_owned
);

  state_t state;
  cmd_t   cmd_q;
  cmd_t   cmd_i;
  ph_t    phase;
  ph_t    ph_nx;
  logic   wbit_q;
  logic   ill_q;
  logic   qtr_tick;
  logic   stretch;
  logic   arb_chk;
  logic   arb;
  logic   run;

  assign cmd_i     = cmd_t'(cmd);
  assign cmd_ready = (state == ST_IDLE);
  assign run       = (state == ST_RUN);
  assign ph_nx     = phase + 1'b1;
  assign stretch   = !scl_oe && !scl_in;

  // Only phases where we release SDA with SCL high can lose.
  assign arb_chk =
    ((cmd_q == CMD_START) && (phase == 2'd1)) ||
    ((cmd_q == CMD_WRITE) && wbit_q) ||
    ((cmd_q == CMD_STOP) && (phase == 2'd2));

  assign arb = run && arb_chk && !sda_oe &&
               !scl_oe && scl_in && !sda_in;

  i2c_qtr_timer #(
    .QTR_DIV (QTR_DIV)
  ) u_tmr (
    .clk      (clk),
    .reset    (reset),
    .enable   (run),
    .hold     (stretch),
    .qtr_tick (qtr_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cmd_q     <= CMD_START;
      wbit_q    <= 1'b0;
      ill_q     <= 1'b0;
      phase     <= '0;
      sda_oe    <= 1'b0;
      scl_oe    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      arb_lost  <= 1'b0;
      rd_bit    <= 1'b0;
      bus_owned <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      arb_lost <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_q  <= cmd_i;
            wbit_q <= cmd_wbit;
            phase  <= '0;
            if (cmd_i != CMD_START && !bus_owned) begin
              ill_q <= 1'b1;
              state <= ST_DONE;
            end else begin
              ill_q <= 1'b0;
              state <= ST_RUN;
              {sda_oe, scl_oe} <=
                line_oe(cmd_i, cmd_wbit, 2'd0, scl_oe);
            end
          end
        end
        ST_RUN: begin
          if (arb) begin
            arb_lost  <= 1'b1;
            sda_oe    <= 1'b0;
            scl_oe    <= 1'b0;
            bus_owned <= 1'b0;
            phase     <= '0;
            state     <= ST_IDLE;
          end else if (qtr_tick) begin
            phase <= ph_nx;
            if (cmd_q == CMD_READ && phase == 2'd2)
              rd_bit <= sda_in;
            if (phase == 2'd3)
              state <= ST_DONE;
            else
              {sda_oe, scl_oe} <=
                line_oe(cmd_q, wbit_q, ph_nx, scl_oe);
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          err   <= ill_q;
          state <= ST_IDLE;
          if (!ill_q && cmd_q == CMD_START)
            bus_owned <= 1'b1;
          if (!ill_q && cmd_q == CMD_STOP)
            bus_owned <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
